// File: rtl/key_event_ctl.sv
// key_event_ctl: decodes PS/2 scancode bytes into held movement keys, fire pulses and pause toggling
module key_event_ctl #(
    parameter int          TIMEOUT_CYCLES = 65_000,
    parameter logic [7:0]  KEY_LEFT       = 8'h1C,
    parameter logic [7:0]  KEY_RIGHT      = 8'h23,
    parameter logic [7:0]  KEY_FIRE       = 8'h29,
    parameter logic [7:0]  KEY_PAUSE      = 8'h4D,
    parameter logic [7:0]  EXT_LEFT       = 8'h6B,
    parameter logic [7:0]  EXT_RIGHT      = 8'h74
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       button_left,
    output logic       button_right,
    output logic       fire_pulse,
    output logic       pause,
    output logic       proto_err
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} state_t;
    state_t state, state_nx;
    logic [CW-1:0] cnt;
    logic hold_a, hold_d, hold_la, hold_ra, hold_fire, pause_held, last_dir;
    logic is_f0, is_e0, expire, make_n, brk_n, make_e, brk_e, l, r;
    // prefix state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end
    // prefix decode and next state; a byte arriving on the expiry cycle takes priority over the timeout
    always_comb begin
        is_f0  = rx_data == 8'hF0;
        is_e0  = rx_data == 8'hE0;
        expire = !rx_valid && state != IDLE && cnt == CW'(TIMEOUT_CYCLES - 1);
        make_n = rx_valid && state == IDLE && !is_f0 && !is_e0;
        brk_n  = rx_valid && state == BRK && !is_f0;
        make_e = rx_valid && state == EXT && !is_f0 && !is_e0;
        brk_e  = rx_valid && state == EXT_BRK && !is_f0;
        state_nx = state;
        if (rx_valid)
            case (state)
                IDLE:    state_nx = is_f0 ? BRK : is_e0 ? EXT : IDLE;
                BRK:     state_nx = is_f0 ? BRK : IDLE;
                EXT:     state_nx = is_f0 ? EXT_BRK : is_e0 ? EXT : IDLE;
                default: state_nx = is_f0 ? EXT_BRK : IDLE;
            endcase
        else if (expire)
            state_nx = IDLE;
    end
    // held keys, direction priority, fire/pause events and the prefix timeout counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt        <= '0;
            proto_err  <= 1'b0;
            fire_pulse <= 1'b0;
            pause      <= 1'b0;
            pause_held <= 1'b0;
            hold_a     <= 1'b0;
            hold_d     <= 1'b0;
            hold_la    <= 1'b0;
            hold_ra    <= 1'b0;
            hold_fire  <= 1'b0;
            last_dir   <= 1'b0;
        end else begin
            cnt        <= (rx_valid || state == IDLE || expire) ? '0 : cnt + 1'b1;
            proto_err  <= expire;
            fire_pulse <= make_n && rx_data == KEY_FIRE && !hold_fire;
            pause      <= (make_n && rx_data == KEY_PAUSE && !pause_held) ? !pause : pause;
            pause_held <= ((make_n || brk_n) && rx_data == KEY_PAUSE) ? make_n : pause_held;
            hold_a     <= ((make_n || brk_n) && rx_data == KEY_LEFT)  ? make_n : hold_a;
            hold_d     <= ((make_n || brk_n) && rx_data == KEY_RIGHT) ? make_n : hold_d;
            hold_fire  <= ((make_n || brk_n) && rx_data == KEY_FIRE)  ? make_n : hold_fire;
            hold_la    <= ((make_e || brk_e) && rx_data == EXT_LEFT)  ? make_e : hold_la;
            hold_ra    <= ((make_e || brk_e) && rx_data == EXT_RIGHT) ? make_e : hold_ra;
            last_dir   <= (make_n && (rx_data == KEY_LEFT || rx_data == KEY_RIGHT)) ? rx_data == KEY_RIGHT :
                          (make_e && (rx_data == EXT_LEFT || rx_data == EXT_RIGHT)) ? rx_data == EXT_RIGHT :
                          last_dir;
        end
    end
    // when both directions are held only the most recently pressed side is reported
    always_comb begin
        l = hold_a | hold_la;
        r = hold_d | hold_ra;
        button_left  = l && (!r || !last_dir);
        button_right = r && (!l || last_dir);
    end
endmodule

// File: tb/tb_key_event_ctl.sv
// tb_key_event_ctl: directed scenario checks for key_event_ctl
module tb_key_event_ctl;
    localparam int T = 20;
    logic clk = 1'b0, rst = 1'b1, rx_valid = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic button_left, button_right, fire_pulse, pause, proto_err;
    int pass = 0, total = 0;

    key_event_ctl #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .button_left(button_left), .button_right(button_right),
        .fire_pulse(fire_pulse), .pause(pause), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    // one-cycle strobe; returns on the falling edge after the byte was clocked in
    task automatic send(input logic [7:0] b);
        @(negedge clk);
        rx_data = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if ({button_left, button_right, fire_pulse, pause, proto_err} !== 5'b0)
            $display("FAIL reset outs got %b want 00000", {button_left, button_right, fire_pulse, pause, proto_err}); else pass++;
    endtask

    task automatic test_left();
        do_reset();
        send(8'h1C);
        total++; if (button_left !== 1'b1) $display("FAIL left_make got %b want 1", button_left); else pass++;
        total++; if (button_right !== 1'b0) $display("FAIL left_make_right got %b want 0", button_right); else pass++;
        send(8'hF0);
        total++; if (button_left !== 1'b1) $display("FAIL left_after_f0 got %b want 1", button_left); else pass++;
        send(8'h1C);
        total++; if (button_left !== 1'b0) $display("FAIL left_break got %b want 0", button_left); else pass++;
        total++; if (button_right !== 1'b0) $display("FAIL left_break_right got %b want 0", button_right); else pass++;
    endtask

    task automatic test_direction();
        do_reset();
        send(8'hE0); send(8'h6B);
        total++; if ({button_left, button_right} !== 2'b10) $display("FAIL ext_left got %b want 10", {button_left, button_right}); else pass++;
        send(8'h23);
        total++; if ({button_left, button_right} !== 2'b01) $display("FAIL last_wins got %b want 01", {button_left, button_right}); else pass++;
        send(8'hE0); send(8'hF0); send(8'h6B);
        total++; if ({button_left, button_right} !== 2'b01) $display("FAIL ext_left_break got %b want 01", {button_left, button_right}); else pass++;
        send(8'h1C);
        total++; if ({button_left, button_right} !== 2'b10) $display("FAIL left_over_right got %b want 10", {button_left, button_right}); else pass++;
    endtask

    task automatic test_fire();
        logic [5:0] seen;
        do_reset();
        send(8'h29); seen[0] = fire_pulse;
        send(8'h29); seen[1] = fire_pulse;
        send(8'h29); seen[2] = fire_pulse;
        send(8'hF0); seen[3] = fire_pulse;
        send(8'h29); seen[4] = fire_pulse;
        send(8'h29); seen[5] = fire_pulse;
        total++; if (seen !== 6'b100001) $display("FAIL fire_seq got %b want 100001", seen); else pass++;
        @(negedge clk);
        total++; if (fire_pulse !== 1'b0) $display("FAIL fire_width got %b want 0", fire_pulse); else pass++;
    endtask

    task automatic test_pause();
        logic [3:0] seen;
        do_reset();
        send(8'h4D); seen[3] = pause;
        send(8'h4D); seen[2] = pause;
        send(8'hF0); send(8'h4D); seen[1] = pause;
        send(8'h4D); seen[0] = pause;
        total++; if (seen !== 4'b1110) $display("FAIL pause_seq got %b want 1110", seen); else pass++;
    endtask

    task automatic test_timeout();
        do_reset();
        send(8'hF0);
        repeat (T - 1) @(negedge clk);
        total++; if (proto_err !== 1'b0) $display("FAIL err_early got %b want 0", proto_err); else pass++;
        @(negedge clk);
        total++; if (proto_err !== 1'b1) $display("FAIL err_pulse got %b want 1", proto_err); else pass++;
        send(8'h1C);
        total++; if (proto_err !== 1'b0) $display("FAIL err_width got %b want 0", proto_err); else pass++;
        total++; if (button_left !== 1'b1) $display("FAIL make_after_to got %b want 1", button_left); else pass++;
    endtask

    task automatic test_expiry_race();
        do_reset();
        send(8'h23);
        total++; if (button_right !== 1'b1) $display("FAIL race_setup got %b want 1", button_right); else pass++;
        send(8'hF0);
        repeat (T - 2) @(negedge clk);
        send(8'h23);
        total++; if (proto_err !== 1'b0) $display("FAIL race_err got %b want 0", proto_err); else pass++;
        total++; if (button_right !== 1'b0) $display("FAIL race_break got %b want 0", button_right); else pass++;
        @(negedge clk);
        total++; if (proto_err !== 1'b0) $display("FAIL race_err_late got %b want 0", proto_err); else pass++;
    endtask

    task automatic test_back_to_back();
        do_reset();
        send(8'h1C);
        send(8'hF0);
        @(negedge clk);
        rx_data = 8'h1C;
        rx_valid = 1'b1;
        @(negedge clk);
        total++; if (button_left !== 1'b0) $display("FAIL b2b_break got %b want 0", button_left); else pass++;
        @(negedge clk);
        rx_valid = 1'b0;
        total++; if (button_left !== 1'b1) $display("FAIL b2b_make got %b want 1", button_left); else pass++;
        send(8'hF0); send(8'h55); send(8'h23);
        total++; if ({button_left, button_right} !== 2'b01) $display("FAIL unmapped_seq got %b want 01", {button_left, button_right}); else pass++;
    endtask

    task automatic test_async_reset();
        do_reset();
        send(8'h4D); send(8'h1C); send(8'hE0);
        total++; if ({button_left, pause} !== 2'b11) $display("FAIL arst_setup got %b want 11", {button_left, pause}); else pass++;
        #2 rst = 1'b1;
        #1;
        total++; if ({button_left, button_right, fire_pulse, pause, proto_err} !== 5'b0)
            $display("FAIL arst_outs got %b want 00000", {button_left, button_right, fire_pulse, pause, proto_err}); else pass++;
        @(negedge clk);
        rst = 1'b0;
        send(8'h6B);
        total++; if ({button_left, button_right} !== 2'b00) $display("FAIL arst_6b got %b want 00", {button_left, button_right}); else pass++;
    endtask

    initial begin
        test_reset();
        test_left();
        test_direction();
        test_fire();
        test_pause();
        test_timeout();
        test_expiry_race();
        test_back_to_back();
        test_async_reset();
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule
